// File: rtl/bus_dma_pkg.sv
// bus_dma_pkg: state encoding for the bus_dma transfer controller.
package bus_dma_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD,
        CAP  = ST_CAP,
        WR   = ST_WR,
        FIN  = ST_FIN
    } state_t;

endpackage

// File: rtl/bus_dma.sv
// bus_dma: single-channel word copy engine on the memory controller bus.
// Fill mode (constant pattern, no reads) is compiled in with `define BUS_DMA_FILL_EN.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    START,
    input  logic [ADDRESS_BITS-1:0] SRC_ADDR,
    input  logic [ADDRESS_BITS-1:0] DST_ADDR,
    input  logic [ADDRESS_BITS-1:0] LEN,
    input  logic                    FILL,
    input  logic [BITS-1:0]         FILL_VALUE,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [ADDRESS_BITS-1:0] ADDRESS,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic [BITS-1:0]         DATA_IN,
    output logic                    memWR,
    output logic                    memRD,
    input  logic                    memBUSY
);

    localparam logic [ADDRESS_BITS-1:0] ONE = ADDRESS_BITS'(1);

    state_t                  state, state_n;
    logic [ADDRESS_BITS-1:0] src, src_n;
    logic [ADDRESS_BITS-1:0] dst, dst_n;
    logic [ADDRESS_BITS-1:0] cnt, cnt_n;
    logic [BITS-1:0]         data, data_n;
    logic                    fill_mode;

`ifdef BUS_DMA_FILL_EN
    logic fill_q, fill_n;

    assign fill_mode = fill_q;

    always_ff @(posedge CLK) begin
        if (!RSTb) fill_q <= 1'b0;
        else       fill_q <= fill_n;
    end
`else
    logic unused_fill;

    assign fill_mode   = 1'b0;
    assign unused_fill = ^{FILL, FILL_VALUE};
`endif

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        cnt_n   = cnt;
        data_n  = data;
`ifdef BUS_DMA_FILL_EN
        fill_n  = fill_q;
`endif
        case (state)
            IDLE: begin
                if (START) begin
                    src_n = SRC_ADDR;
                    dst_n = DST_ADDR;
                    cnt_n = LEN;
`ifdef BUS_DMA_FILL_EN
                    fill_n = FILL;
                    if (FILL) data_n = FILL_VALUE;
                    if (LEN == '0)  state_n = FIN;
                    else if (FILL)  state_n = WR;
                    else            state_n = RD;
`else
                    state_n = (LEN == '0) ? FIN : RD;
`endif
                end
            end
            RD:  if (!memBUSY) state_n = CAP;
            CAP: begin
                data_n  = DATA_IN;
                state_n = WR;
            end
            WR: begin
                // A stalled write leaves every pointer untouched so the bus holds.
                if (!memBUSY) begin
                    src_n = src + ONE;
                    dst_n = dst + ONE;
                    cnt_n = cnt - ONE;
                    if (cnt == ONE)     state_n = FIN;
                    else if (fill_mode) state_n = WR;
                    else                state_n = RD;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= only; bus outputs are registered from the
    // next-state view so they change exactly when the FSM enters RD or WR.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state    <= IDLE;
            src      <= '0;
            dst      <= '0;
            cnt      <= '0;
            data     <= '0;
            ADDRESS  <= '0;
            DATA_OUT <= '0;
            memRD    <= 1'b0;
            memWR    <= 1'b0;
        end else begin
            state <= state_n;
            src   <= src_n;
            dst   <= dst_n;
            cnt   <= cnt_n;
            data  <= data_n;
            memRD <= (state_n == RD);
            memWR <= (state_n == WR);
            if (state_n == RD)      ADDRESS <= src_n;
            else if (state_n == WR) ADDRESS <= dst_n;
            if (state_n == WR)      DATA_OUT <= data_n;
        end
    end

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: directed scoreboard bench for bus_dma with a one-cycle-latency memory model.
module tb_bus_dma;

    logic        CLK;
    logic        RSTb;
    logic        START;
    logic [15:0] SRC_ADDR, DST_ADDR, LEN;
    logic        FILL;
    logic [15:0] FILL_VALUE;
    logic        BUSY, DONE;
    logic [15:0] ADDRESS, DATA_OUT, DATA_IN;
    logic        memWR, memRD, memBUSY;

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    logic [15:0] mem [logic [15:0]];

    bus_dma #(.BITS(16), .ADDRESS_BITS(16)) dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .START     (START),
        .SRC_ADDR  (SRC_ADDR),
        .DST_ADDR  (DST_ADDR),
        .LEN       (LEN),
        .FILL      (FILL),
        .FILL_VALUE(FILL_VALUE),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ADDRESS   (ADDRESS),
        .DATA_OUT  (DATA_OUT),
        .DATA_IN   (DATA_IN),
        .memWR     (memWR),
        .memRD     (memRD),
        .memBUSY   (memBUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0BAD;
    endfunction

    // Memory model: write commits when memWR is not stalled; read data appears
    // only in the cycle after an accepted read address.
    always begin
        logic        rd_pend;
        logic [15:0] rd_addr;
        @(negedge CLK);
        if (memWR && !memBUSY) mem[ADDRESS] = DATA_OUT;
        rd_pend = memRD && !memBUSY;
        rd_addr = ADDRESS;
        @(posedge CLK);
        #1;
        DATA_IN = rd_pend ? mem_rd(rd_addr) : 16'hDEAD;
    end

    // Scoreboard monitor: every completed bus access pops one expectation.
    always @(negedge CLK) begin
        if (memRD || memWR) check("rd_wr_exclusive", 32'(memRD & memWR), 32'd0);
        if (memRD && !memBUSY) begin
            if (exp_rd.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: ADDRESS=%h, no read expected", ADDRESS);
            end else begin
                check("read_addr", 32'(ADDRESS), 32'(exp_rd.pop_front()));
            end
        end
        if (memWR && !memBUSY) begin
            if (exp_wr.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: ADDRESS=%h DATA_OUT=%h, no write expected",
                         ADDRESS, DATA_OUT);
            end else begin
                check("write_addr_data", {ADDRESS, DATA_OUT}, exp_wr.pop_front());
            end
        end
    end

    task automatic run_xfer(input string name, input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input logic fill, input logic [15:0] fv,
                            input int exp_done, input bit poke);
        int done_k = 0;
        int busy_n = 0;
        @(posedge CLK); #1;
        START = 1'b1; SRC_ADDR = src; DST_ADDR = dst; LEN = len; FILL = fill; FILL_VALUE = fv;
        @(posedge CLK); #1;
        START = 1'b0; SRC_ADDR = ~src; DST_ADDR = ~dst; LEN = len + 16'd7;
        FILL = ~fill; FILL_VALUE = ~fv;
        for (int k = 1; k <= 400; k++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (DONE) begin
                done_k = k;
                break;
            end
            @(posedge CLK); #1;
            START = poke && (k == 3);
        end
        START = 1'b0;
        check({name, "_done_cycle"}, 32'(done_k), 32'(exp_done));
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_done));
        @(negedge CLK);
        check({name, "_done_one_cycle"}, 32'(DONE), 32'd0);
        check({name, "_idle_after"}, 32'(BUSY), 32'd0);
        check({name, "_reads_left"}, 32'(exp_rd.size()), 32'd0);
        check({name, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    // Stalls the write to 0x8001 for four cycles and checks the bus holds.
    task automatic stall_second_write();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge CLK); #1;
            if (memWR && ADDRESS == 16'h8001) seen = 1'b1;
        end
        check("stall_trigger_seen", 32'(seen), 32'd1);
        memBUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("stall_hold_addr", 32'(ADDRESS), 32'h8001);
            check("stall_hold_wr", 32'(memWR), 32'd1);
            check("stall_hold_data", 32'(DATA_OUT), 32'h2222);
            @(posedge CLK); #1;
        end
        memBUSY = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat [4];
        pat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int i = 0; i < 4; i++) mem[16'h4000 + 16'(i)] = pat[i];
        mem[16'hFFFF] = 16'hBEEF;
        mem[16'h0000] = 16'hCAFE;

        RSTb = 1'b0; START = 1'b0; SRC_ADDR = '0; DST_ADDR = '0; LEN = '0;
        FILL = 1'b0; FILL_VALUE = '0; memBUSY = 1'b0; DATA_IN = 16'hDEAD;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_strobes", 32'({memRD, memWR}), 32'd0);
        check("reset_address", 32'(ADDRESS), 32'd0);
        check("reset_data_out", 32'(DATA_OUT), 32'd0);
        @(posedge CLK); #1;
        RSTb = 1'b1;

        // Plain copy, with a START pulse during the transfer that must be ignored.
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(16'h4000 + 16'(i));
            exp_wr.push_back({16'h8000 + 16'(i), pat[i]});
        end
        run_xfer("copy", 16'h4000, 16'h8000, 16'd3, 1'b0, 16'h0, 10, 1'b1);

        run_xfer("len0", 16'h4000, 16'h8000, 16'd0, 1'b0, 16'h0, 1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(16'h4000 + 16'(i));
            exp_wr.push_back({16'h8000 + 16'(i), pat[i]});
        end
        fork
            run_xfer("stall", 16'h4000, 16'h8000, 16'd3, 1'b0, 16'h0, 14, 1'b0);
            stall_second_write();
        join

        exp_rd.push_back(16'hFFFF);
        exp_rd.push_back(16'h0000);
        exp_wr.push_back({16'h7FFF, 16'hBEEF});
        exp_wr.push_back({16'h8000, 16'hCAFE});
        run_xfer("wrap", 16'hFFFF, 16'h7FFF, 16'd2, 1'b0, 16'h0, 7, 1'b0);

`ifdef BUS_DMA_FILL_EN
        for (int i = 0; i < 4; i++) exp_wr.push_back({16'hC000 + 16'(i), 16'hA5A5});
        run_xfer("fill", 16'h4000, 16'hC000, 16'd4, 1'b1, 16'hA5A5, 5, 1'b0);
`else
        for (int i = 0; i < 4; i++) begin
            exp_rd.push_back(16'h4000 + 16'(i));
            exp_wr.push_back({16'hC000 + 16'(i), pat[i]});
        end
        run_xfer("fill_as_copy", 16'h4000, 16'hC000, 16'd4, 1'b1, 16'hA5A5, 13, 1'b0);
`endif

        // Abort during CAP of word 2 of 5: only the first word reaches the bus.
        exp_rd.push_back(16'h4000);
        exp_rd.push_back(16'h4001);
        exp_wr.push_back({16'hD000, 16'h1111});
        @(posedge CLK); #1;
        START = 1'b1; SRC_ADDR = 16'h4000; DST_ADDR = 16'hD000; LEN = 16'd5; FILL = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
        RSTb = 1'b0;
        @(negedge CLK);
        check("abort_in_cap_busy", 32'(BUSY), 32'd1);
        @(negedge CLK);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_strobes", 32'({memRD, memWR}), 32'd0);
        check("abort_address", 32'(ADDRESS), 32'd0);
        check("abort_data_out", 32'(DATA_OUT), 32'd0);
        @(posedge CLK); #1;
        RSTb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("abort_no_done", 32'({DONE, BUSY}), 32'd0);
        end
        check("abort_reads_left", 32'(exp_rd.size()), 32'd0);
        check("abort_writes_left", 32'(exp_wr.size()), 32'd0);

        exp_rd.push_back(16'h4002);
        exp_wr.push_back({16'hE000, 16'h3333});
        run_xfer("after_abort", 16'h4002, 16'hE000, 16'd1, 1'b0, 16'h0, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 Parameter BITS, 16, data word width.
REQ-002 Parameter ADDRESS_BITS, 16, word-address width.
REQ-003 CLK  in  1  clock; all logic SHALL be on the rising edge.
REQ-004 RSTb  in  1  reset, synchronous, active-low.
REQ-005 START  in  1  one-cycle request to begin a transfer; SHALL be sampled only in IDLE.
REQ-006 SRC_ADDR  in  ADDRESS_BITS  first source word address, latched on accepted START.
REQ-007 DST_ADDR  in  ADDRESS_BITS  first destination word address, latched on accepted START.
REQ-008 LEN  in  ADDRESS_BITS  word count, latched on accepted START.
REQ-009 FILL  in  1  fill-mode select, latched on accepted START (see Configuration).
REQ-010 FILL_VALUE  in  BITS  fill pattern, latched on accepted START.
REQ-011 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-012 DONE  out  1  one-cycle pulse on the cycle after the last write, or after START with LEN=0.
REQ-013 ADDRESS  out  ADDRESS_BITS  bus address to the memory controller.
REQ-014 DATA_OUT  out  BITS  write data to the controller's DATA_IN.
REQ-015 DATA_IN  in  BITS  read data from the controller's DATA_OUT; valid one cycle after a read address.
REQ-016 memWR  out  1  write strobe.
REQ-017 memRD  out  1  read request.
REQ-018 memBUSY  in  1  controller stall.

Function
REQ-019 The FSM SHALL have states IDLE, RD, CAP, WR and FIN.
REQ-020 IDLE SHALL go to RD on START with LEN!=0 and FILL=0, to WR when FILL=1, and to FIN when LEN=0.
REQ-021 RD SHALL drive ADDRESS=src and memRD=1, then go to CAP.
REQ-022 CAP SHALL drive no strobe, latch DATA_IN into the data register, then go to WR; read latency is exactly one cycle.
REQ-023 WR SHALL drive ADDRESS=dst, DATA_OUT=data register, memWR=1, then increment src and dst and decrement the count.
REQ-024 After WR, the FSM SHALL go to FIN on the last word, otherwise to RD (copy mode) or WR (fill mode).
REQ-025 FIN SHALL assert DONE for one cycle and return to IDLE.
REQ-026 Throughput SHALL be 3 cycles/word in copy mode and 1 cycle/word in fill mode, plus 1 FIN cycle.
REQ-027 While memBUSY=1 in RD or WR, the FSM SHALL hold its state, ADDRESS, DATA_OUT and strobes, and SHALL complete the access in the first cycle memBUSY=0.
REQ-028 memBUSY SHALL be ignored in IDLE, CAP and FIN.
REQ-029 Address increments SHALL wrap modulo 2^ADDRESS_BITS; the count SHALL be ADDRESS_BITS wide, so the maximum transfer is 2^ADDRESS_BITS-1 words.
REQ-030 START while BUSY=1 SHALL be ignored; input changes after acceptance SHALL have no effect.
REQ-031 memRD and memWR SHALL never be high in the same cycle, and both SHALL be 0 outside RD and WR.
REQ-032 Outside WR, DATA_OUT SHALL hold its last value; outside RD and WR, ADDRESS SHALL hold its last value.

Reset
REQ-033 While RSTb=0, the block SHALL force state IDLE and set BUSY, DONE, memWR, memRD, ADDRESS, DATA_OUT, the counter and the data register to 0.
REQ-034 Reset mid-transfer SHALL abort with no further bus access and no DONE pulse.

Configuration
REQ-035 Macro BUS_DMA_FILL_EN SHALL compile fill mode in.
REQ-036 With BUS_DMA_FILL_EN defined, FILL=1 SHALL write FILL_VALUE to LEN consecutive destination words with no reads.
REQ-037 Without BUS_DMA_FILL_EN, FILL and FILL_VALUE SHALL be ignored, every transfer SHALL be a copy, and no fill logic SHALL be synthesised.

Structure
REQ-038 Package bus_dma_pkg SHALL hold the state enumeration and its encoding constants.
REQ-039 The block SHALL be a single module with no sub-module; the controller-side port names SHALL mirror the memory controller's bus.

Verification
REQ-040 Copy: SRC=0x4000, DST=0x8000, LEN=3, memory 0x4000..2 = 0x1111/0x2222/0x3333 -> 0x8000..2 hold the same values, DONE pulses at cycle 10 after START, BUSY is high for cycles 1..10.
REQ-041 LEN=0: START -> DONE pulses on the next cycle, and memRD and memWR stay 0.
REQ-042 Stall: memBUSY=1 for 4 cycles during the second WR -> ADDRESS=0x8001 and memWR are held all 4 cycles, the final data is correct, and DONE is delayed by exactly 4 cycles.
REQ-043 Wrap: SRC=0xFFFF, DST=0x7FFF, LEN=2 -> reads 0xFFFF then 0x0000, writes 0x7FFF then 0x8000.
REQ-044 Fill (BUS_DMA_FILL_EN): DST=0xC000, LEN=4, FILL_VALUE=0xA5A5 -> 4 consecutive write cycles, no memRD, DONE on cycle 5; without the macro, the same stimulus performs a copy.
REQ-045 Reset/abort: RSTb low during CAP of word 2 of 5 -> all outputs 0 on the next edge, no DONE, and a subsequent START is accepted normally.
